datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Multi-cycle control unit for the regfile/ALU/RAM datapath. Accepts one operation per
//  valid/ready handshake (ALU reg-reg, LOAD, STORE, MOVI) and drives the register
//  selects, ALU function/carry, RAM write enable and writeback mux. It replaces the
//  hand-driven control lines used so far and pulses done with the captured ALU status.
// PARAMETERS
//  REG_AW    5   register address width (A, B, regSel)
//  FS_W      5   ALU function-select width
//  DATA_W    64  immediate / write-data width
//  STAT_W    4   ALU status (SIGNAL) width
//  CNT_W     16  completed-operation counter width
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       synchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       sequencer can accept (high only in IDLE)
//  req_op      in   2       00 ALU, 01 LOAD, 10 STORE, 11 MOVI
//  req_rd      in   REG_AW  destination register
//  req_ra      in   REG_AW  source A (LOAD/STORE: RAM address register)
//  req_rb      in   REG_AW  source B (STORE: data register)
//  req_fs      in   FS_W    ALU function select (ALU op only)
//  req_ci      in   1       ALU carry-in (ALU op only)
//  req_imm     in   DATA_W  immediate (MOVI only)
//  status_in   in   STAT_W  ALU status flags from datapath
//  A, B        out  REG_AW  register read selects
//  regSel      out  REG_AW  register write select
//  wrt         out  1       register-file write enable
//  FS          out  FS_W    ALU function select
//  CO          out  1       ALU carry-in
//  RAMwrt      out  1       RAM write enable
//  wb_sel      out  2       writeback mux: 00 ALU, 01 RAM, 10 immediate
//  wdata_imm   out  DATA_W  immediate onto register write-data bus
//  busy        out  1       high in any state other than IDLE
//  done        out  1       one-cycle pulse when an op retires
//  done_status out  STAT_W  ALU status of the retiring op (0 for non-ALU ops)
//  op_count    out  CNT_W   retired-op counter, wraps to 0
// BEHAVIOUR
//  - All outputs registered. While reset==0 at a clock edge, every output goes to 0 and
//    state goes to IDLE; req_ready is 0 during reset and 1 from the first non-reset IDLE cycle.
//  - Accept: req_valid & req_ready at edge T. The request fields are latched; inputs are
//    ignored until the next IDLE.
//  - States: IDLE, EXEC, MEM, WB, DONE.
//    ALU  : EXEC (A=ra, B=rb, FS=fs, CO=ci; status_in sampled at end of EXEC) -> WB -> DONE
//    LOAD : EXEC (A=ra) -> MEM (1-cycle RAM read) -> WB (wb_sel=01) -> DONE
//    STORE: EXEC (A=ra, B=rb, RAMwrt=1 for exactly this cycle) -> DONE
//    MOVI : WB (wb_sel=10, wdata_imm=imm) -> DONE
//  - WB: wrt=1, regSel=rd for exactly one cycle; wrt=0 in every other state.
//  - DONE: done=1 and done_status valid for one cycle; op_count increments (wraps
//    2^CNT_W-1 -> 0). Next state is IDLE.
//  - Latency from accept edge T to the done cycle: ALU T+3, LOAD T+4, STORE T+2,
//    MOVI T+2. Minimum spacing between accepts is latency+1.
//  - A, B, FS and CO hold their values through MEM/WB/DONE. They return to 0 in IDLE.
//  - rd==0 is not special-cased. It is written like any other register.
//  - Reset during any state aborts the op: no wrt/RAMwrt in the reset cycle, no done,
//    and op_count is cleared.
//  - req_valid held high in a non-IDLE state has no effect.
// STRUCTURE
//  - Package datapath_seq_pkg: op encodings (OP_ALU..OP_MOVI), wb_sel encodings
//    (WB_ALU/WB_RAM/WB_IMM), state enum, default widths.
//  - Single module. No sub-module: FSM plus a request-latch register and the counter.
// TESTING
//  1. Reset held 3 cycles -> all outputs 0. Release -> req_ready=1, busy=0, op_count=0.
//  2. ALU ra=3 rb=4 rd=5 fs=2 ci=1, status_in=4'b1010 -> A=3, B=4, FS=2, CO=1 at T+1;
//     wrt=1 regSel=5 wb_sel=00 at T+2; done=1 done_status=1010 at T+3.
//  3. LOAD ra=7 rd=9 -> wrt=1 regSel=9 wb_sel=01 at T+3, done at T+4.
//     STORE ra=7 rb=2 -> RAMwrt=1 only at T+1, wrt never set, done at T+2.
//  4. MOVI rd=1 imm=64'h1CC4 -> wdata_imm=1CC4 wb_sel=10 wrt=1 at T+1, done at T+2.
//     req_valid held high throughout -> the next accept occurs at the first IDLE.
//  5. Reset asserted in the MEM state of a LOAD -> no wrt, no done, op_count=0, IDLE.
//  6. Preload op_count=16'hFFFF via 65535 MOVIs, then one more op -> op_count=0.

Source files
------------

// File: rtl/datapath_seq_pkg.sv
// Shared encodings and default widths for the datapath sequencer.
package datapath_seq_pkg;

  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned DEF_FS_W   = 5;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_STAT_W = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_MOVI  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_RAM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMem,
    StWb,
    StDone
  } state_e;

endpackage

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the regfile/ALU/RAM datapath. Every control output is a
// register loaded from the current FSM state, so each state becomes visible on the pins
// one cycle after the FSM enters it.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned FS_W   = DEF_FS_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned STAT_W = DEF_STAT_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rb,
  input  logic [FS_W-1:0]   req_fs,
  input  logic              req_ci,
  input  logic [DATA_W-1:0] req_imm,
  input  logic [STAT_W-1:0] status_in,
  output logic [REG_AW-1:0] A,
  output logic [REG_AW-1:0] B,
  output logic [REG_AW-1:0] regSel,
  output logic              wrt,
  output logic [FS_W-1:0]   FS,
  output logic              CO,
  output logic              RAMwrt,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] wdata_imm,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] done_status,
  output logic [CNT_W-1:0]  op_count
);

  state_e state_q, state_d;

  // Latched request
  logic [1:0]        op_q;
  logic [REG_AW-1:0] rd_q, ra_q, rb_q;
  logic [FS_W-1:0]   fs_q;
  logic              ci_q;
  logic [DATA_W-1:0] imm_q;
  logic [STAT_W-1:0] stat_q, stat_d;

  // Output registers
  logic              ready_q, ready_d, busy_q, busy_d;
  logic [REG_AW-1:0] a_q, a_d, b_q, b_d, regsel_q, regsel_d;
  logic              wrt_q, wrt_d, co_q, co_d, ramwrt_q, ramwrt_d, done_q, done_d;
  logic [FS_W-1:0]   fs_out_q, fs_out_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STAT_W-1:0] dstat_q, dstat_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic accept;
  // ready_q can only be high while state_q is IDLE, so this is the IDLE handshake
  assign accept = req_valid & ready_q;

  // Next-state sequencing per operation type
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (req_op == OP_MOVI) ? StWb : StExec;
      StExec: begin
        if (op_q == OP_LOAD)       state_d = StMem;
        else if (op_q == OP_STORE) state_d = StDone;
        else                       state_d = StWb;
      end
      StMem:   state_d = StWb;
      StWb:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control word for the next cycle, derived from the state being left
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    fs_out_d = fs_out_q;
    co_d     = co_q;
    stat_d   = stat_q;
    count_d  = count_q;
    regsel_d = '0;
    wrt_d    = 1'b0;
    ramwrt_d = 1'b0;
    wb_sel_d = WB_ALU;
    wdata_d  = '0;
    done_d   = 1'b0;
    dstat_d  = '0;
    // Ready tracks the state being entered so a retiring op can be followed back-to-back
    ready_d  = (state_d == StIdle);
    busy_d   = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        a_d      = '0;
        b_d      = '0;
        fs_out_d = '0;
        co_d     = 1'b0;
        stat_d   = '0;
      end
      StExec: begin
        a_d = ra_q;
        if (op_q != OP_LOAD) b_d = rb_q;
        if (op_q == OP_ALU) begin
          fs_out_d = fs_q;
          co_d     = ci_q;
        end
        ramwrt_d = (op_q == OP_STORE);
      end
      StMem: ;
      StWb: begin
        wrt_d    = 1'b1;
        regsel_d = rd_q;
        if (op_q == OP_LOAD) begin
          wb_sel_d = WB_RAM;
        end else if (op_q == OP_MOVI) begin
          wb_sel_d = WB_IMM;
          wdata_d  = imm_q;
        end
        // Pins are showing the EXEC control word this cycle, so status_in is its result
        if (op_q == OP_ALU) stat_d = status_in;
      end
      StDone: begin
        done_d  = 1'b1;
        dstat_d = stat_q;
        count_d = count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // State, request latch and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OP_ALU;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      fs_q     <= '0;
      ci_q     <= 1'b0;
      imm_q    <= '0;
      stat_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      regsel_q <= '0;
      wrt_q    <= 1'b0;
      fs_out_q <= '0;
      co_q     <= 1'b0;
      ramwrt_q <= 1'b0;
      wb_sel_q <= WB_ALU;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      dstat_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      if (accept) begin
        op_q  <= req_op;
        rd_q  <= req_rd;
        ra_q  <= req_ra;
        rb_q  <= req_rb;
        fs_q  <= req_fs;
        ci_q  <= req_ci;
        imm_q <= req_imm;
      end
      stat_q   <= stat_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      regsel_q <= regsel_d;
      wrt_q    <= wrt_d;
      fs_out_q <= fs_out_d;
      co_q     <= co_d;
      ramwrt_q <= ramwrt_d;
      wb_sel_q <= wb_sel_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      dstat_q  <= dstat_d;
      count_q  <= count_d;
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign A           = a_q;
  assign B           = b_q;
  assign regSel      = regsel_q;
  assign wrt         = wrt_q;
  assign FS          = fs_out_q;
  assign CO          = co_q;
  assign RAMwrt      = ramwrt_q;
  assign wb_sel      = wb_sel_q;
  assign wdata_imm   = wdata_q;
  assign done        = done_q;
  assign done_status = dstat_q;
  assign op_count    = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: per-cycle control traces for selected ops and a
// done monitor that pops expected status/count entries pushed at each accept.
module tb_datapath_sequencer;
  import datapath_seq_pkg::*;

  localparam int unsigned RegAw = 5;
  localparam int unsigned FsW   = 5;
  localparam int unsigned DataW = 64;
  localparam int unsigned StatW = 4;
  // Narrow counter keeps the wrap test short
  localparam int unsigned CntW  = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [RegAw-1:0] req_rd = '0, req_ra = '0, req_rb = '0;
  logic [FsW-1:0]   req_fs = '0;
  logic             req_ci = 1'b0;
  logic [DataW-1:0] req_imm = '0;
  logic [StatW-1:0] status_in = '0;
  logic [RegAw-1:0] A, B, regSel;
  logic             wrt, CO, RAMwrt, busy, done;
  logic [FsW-1:0]   FS;
  logic [1:0]       wb_sel;
  logic [DataW-1:0] wdata_imm;
  logic [StatW-1:0] done_status;
  logic [CntW-1:0]  op_count;

  datapath_sequencer #(
    .REG_AW(RegAw), .FS_W(FsW), .DATA_W(DataW), .STAT_W(StatW), .CNT_W(CntW)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb), .req_fs(req_fs),
    .req_ci(req_ci), .req_imm(req_imm), .status_in(status_in), .A(A), .B(B),
    .regSel(regSel), .wrt(wrt), .FS(FS), .CO(CO), .RAMwrt(RAMwrt), .wb_sel(wb_sel),
    .wdata_imm(wdata_imm), .busy(busy), .done(done), .done_status(done_status),
    .op_count(op_count)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct packed {
    logic [StatW-1:0] status;
    logic [CntW-1:0]  count;
  } exp_t;

  exp_t            exp_q[$];
  logic [CntW-1:0] model_count = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Retire monitor: each done pulse must match the oldest accepted op
  always @(negedge clock) begin : done_monitor
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", done, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("done_status", done_status, e.status);
        check_eq("done_op_count", op_count, e.count);
      end
    end
  end

  // Drive one op, wait for its accept, then walk its latency checking the control pins
  task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] fs, input logic ci,
                        input logic [63:0] imm, input logic [3:0] stat, input bit hold,
                        input bit detail, output int waited);
    int lat, wbk;
    bit wbc;
    lat = (op == OP_ALU) ? 3 : (op == OP_LOAD) ? 4 : 2;
    wbk = (op == OP_ALU) ? 2 : (op == OP_LOAD) ? 3 : (op == OP_MOVI) ? 1 : -1;
    req_op = op; req_rd = rd; req_ra = ra; req_rb = rb; req_fs = fs; req_ci = ci;
    req_imm = imm; req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check_eq("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    model_count = model_count + 1'b1;
    exp_q.push_back(exp_t'{status: (op == OP_ALU) ? stat : 4'h0, count: model_count});
    status_in = ~stat;
    @(posedge clock);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
    // Scramble fields: the latched copy must be used from here on
    req_rd = ~rd; req_ra = ~ra; req_rb = ~rb; req_fs = ~fs; req_ci = ~ci; req_imm = ~imm;
    req_op = ~op;
    if (detail) begin
      check_eq("k0_busy", busy, 1);
      check_eq("k0_ready", req_ready, 0);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      status_in = (k == 1) ? stat : ~stat;
      if (detail) begin
        wbc = (k == wbk);
        check_eq($sformatf("k%0d_A", k), A, (op != OP_MOVI) ? ra : 5'd0);
        check_eq($sformatf("k%0d_B", k), B, (op == OP_ALU || op == OP_STORE) ? rb : 5'd0);
        check_eq($sformatf("k%0d_FS", k), FS, (op == OP_ALU) ? fs : 5'd0);
        check_eq($sformatf("k%0d_CO", k), CO, (op == OP_ALU) ? ci : 1'b0);
        check_eq($sformatf("k%0d_wrt", k), wrt, wbc);
        check_eq($sformatf("k%0d_regSel", k), regSel, wbc ? rd : 5'd0);
        check_eq($sformatf("k%0d_wb_sel", k), wb_sel,
                 !wbc ? 2'b00 : (op == OP_LOAD) ? 2'b01 : (op == OP_MOVI) ? 2'b10 : 2'b00);
        check_eq($sformatf("k%0d_wdata_imm", k), wdata_imm,
                 (wbc && op == OP_MOVI) ? imm : 64'd0);
        check_eq($sformatf("k%0d_RAMwrt", k), RAMwrt, (op == OP_STORE && k == 1));
        check_eq($sformatf("k%0d_done", k), done, (k == lat));
        check_eq($sformatf("k%0d_busy", k), busy, (k < lat));
        check_eq($sformatf("k%0d_ready", k), req_ready, (k == lat));
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int w;
    int gap;
    // Reset held for three edges
    repeat (3) begin
      @(negedge clock);
      check_eq("rst_ctl", {A, B, regSel, wrt, FS, CO, RAMwrt, wb_sel, busy, done,
                           done_status, op_count, req_ready}, 0);
      check_eq("rst_wdata", wdata_imm, 0);
    end
    reset = 1'b1;
    @(negedge clock);
    check_eq("post_rst_ready", req_ready, 1);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_count", op_count, 0);

    // ALU, LOAD, STORE traces
    run_op(OP_ALU, 5'd5, 5'd3, 5'd4, 5'd2, 1'b1, 64'd0, 4'b1010, 1'b0, 1'b1, w);
    run_op(OP_LOAD, 5'd9, 5'd7, 5'd0, 5'd0, 1'b0, 64'd0, 4'b0110, 1'b0, 1'b1, w);
    run_op(OP_STORE, 5'd11, 5'd7, 5'd2, 5'd0, 1'b0, 64'd0, 4'b1111, 1'b0, 1'b1, w);

    // MOVI with valid held high, then an ALU to rd=0 accepted at the first IDLE
    run_op(OP_MOVI, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 64'h1CC4, 4'b0011, 1'b1, 1'b1, w);
    run_op(OP_ALU, 5'd0, 5'd31, 5'd30, 5'd17, 1'b0, 64'd0, 4'b0101, 1'b0, 1'b1, gap);
    check_eq("hold_accept_gap", gap, 0);
    repeat (2) @(negedge clock);

    // LOAD aborted by reset while its MEM cycle is on the pins
    req_op = OP_LOAD; req_ra = 5'd7; req_rd = 5'd9; req_valid = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    check_eq("abort_accept", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("abort_wrt", wrt, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_count", op_count, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready_in_rst", req_ready, 0);
    reset = 1'b1;
    model_count = '0;
    @(negedge clock);
    check_eq("abort_ready", req_ready, 1);
    check_eq("abort_count_after", op_count, 0);
    repeat (3) begin
      @(negedge clock);
      check_eq("abort_no_wrt", wrt, 0);
    end

    // Counter wrap: fill to all-ones, then one more op wraps to zero
    while (model_count != {CntW{1'b1}}) begin
      run_op(OP_MOVI, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 64'(model_count), 4'h0, 1'b0, 1'b0, w);
    end
    check_eq("count_full", op_count, {CntW{1'b1}});
    run_op(OP_ALU, 5'd6, 5'd1, 5'd2, 5'd3, 1'b1, 64'd0, 4'b1001, 1'b0, 1'b1, w);
    check_eq("count_wrapped", op_count, 0);

    repeat (4) @(negedge clock);
    check_eq("pending_done", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
